// File: rtl/data_mem_responder.sv
// data_mem_responder
// Far end of the processor data port (DataAddr/DataOut/WriteData/ReadData/
// DataIn/DataDone). It accepts one request per cycle with no back-pressure.
// A request that is sampled at the edge ending cycle c completes in cycle
// c+READ_LATENCY.
//
// Pipeline organisation:
//   - Stage 0 holds the registered memory read. Stages 1..READ_LATENCY-1
//     shift that word forward.
//   - DataDone is the valid bit of the last stage.
//   - DataIn shows the last stage's word when a read completes. Otherwise it
//     shows the value held from the most recent read completion.
//
// Optional feature: define DATA_MEM_STATS_EN to add the saturating
// ReadCount/WriteCount outputs.
module data_mem_responder #(
  parameter int WORD_SIZE    = 16,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WORD_SIZE-1:0] DataAddr,
  input  logic [WORD_SIZE-1:0] DataOut,
  input  logic                 WriteData,
  input  logic                 ReadData,
  output logic [WORD_SIZE-1:0] DataIn,
  output logic                 DataDone,
`ifdef DATA_MEM_STATS_EN
  output logic [WORD_SIZE-1:0] ReadCount,
  output logic [WORD_SIZE-1:0] WriteCount,
`endif
  output logic                 AddrErr
);

  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int LAST      = READ_LATENCY - 1;

  // Storage has no reset, so it can map onto block RAM.
  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] addr_idx;
  logic                 addr_oor;
  logic                 req_read;
  logic                 req_write;
  logic                 req_illegal;

  // Per-stage token flags. These are cleared by reset.
  logic [READ_LATENCY-1:0] stg_valid_reg;
  logic [READ_LATENCY-1:0] stg_read_reg;
  logic                    stg0_oor_reg;

  // Per-stage data. This is qualified by the valid flags, so it has no reset.
  logic [WORD_SIZE-1:0] stg_data_reg [READ_LATENCY];
  logic [WORD_SIZE-1:0] stage_word   [READ_LATENCY];

  logic [WORD_SIZE-1:0] data_hold_reg;
  logic                 addr_err_reg;
  logic                 last_is_read;

  assign addr_idx    = DataAddr[ADDR_BITS-1:0];
  assign req_illegal = ReadData & WriteData;
  assign req_read    = ReadData & ~WriteData;
  assign req_write   = WriteData & ~ReadData;

  // Any set bit above the index field makes the request out of range.
  // When DEPTH spans the whole address space, no request is out of range.
  generate
    if (ADDR_BITS < WORD_SIZE) begin : g_oor
      assign addr_oor = |DataAddr[WORD_SIZE-1:ADDR_BITS];
    end else begin : g_no_oor
      assign addr_oor = 1'b0;
    end
  endgenerate

  // Each stage's word as seen downstream.
  // An out-of-range read is forced to zero as it leaves stage 0.
  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage_word
      if (gi == 0) begin : g_first
        assign stage_word[gi] = stg0_oor_reg ? '0 : stg_data_reg[gi];
      end else begin : g_rest
        assign stage_word[gi] = stg_data_reg[gi];
      end
    end
  endgenerate

  // Memory write commits at the sampling edge.
  // A read in the next cycle therefore sees the new data.
  always_ff @(posedge Clock) begin
    if (req_write && !addr_oor) begin
      mem[addr_idx] <= DataOut;
    end
  end

  // Registered memory read into stage 0, followed by the data shift chain.
  always_ff @(posedge Clock) begin
    stg_data_reg[0] <= mem[addr_idx];
    for (int k = 1; k < READ_LATENCY; k++) begin
      stg_data_reg[k] <= stage_word[k-1];
    end
  end

  // Token pipeline, read-result hold register and sticky error flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stg_valid_reg <= '0;
      stg_read_reg  <= '0;
      stg0_oor_reg  <= 1'b0;
      data_hold_reg <= '0;
      addr_err_reg  <= 1'b0;
    end else begin
      stg_valid_reg[0] <= req_read | req_write;
      stg_read_reg[0]  <= req_read;
      stg0_oor_reg     <= addr_oor;
      for (int k = 1; k < READ_LATENCY; k++) begin
        stg_valid_reg[k] <= stg_valid_reg[k-1];
        stg_read_reg[k]  <= stg_read_reg[k-1];
      end
      if (last_is_read) begin
        data_hold_reg <= stage_word[LAST];
      end
      if (req_illegal || ((req_read || req_write) && addr_oor)) begin
        addr_err_reg <= 1'b1;
      end
    end
  end

  assign last_is_read = stg_valid_reg[LAST] & stg_read_reg[LAST];
  assign DataDone     = stg_valid_reg[LAST];
  assign DataIn       = last_is_read ? stage_word[LAST] : data_hold_reg;
  assign AddrErr      = addr_err_reg;

`ifdef DATA_MEM_STATS_EN
  logic [WORD_SIZE-1:0] read_count_reg;
  logic [WORD_SIZE-1:0] write_count_reg;

  // Saturating counters of accepted requests.
  // Out-of-range requests are counted; illegal requests are not.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      read_count_reg  <= '0;
      write_count_reg <= '0;
    end else begin
      if (req_read && read_count_reg != '1) begin
        read_count_reg <= read_count_reg + 1'b1;
      end
      if (req_write && write_count_reg != '1) begin
        write_count_reg <= write_count_reg + 1'b1;
      end
    end
  end

  assign ReadCount  = read_count_reg;
  assign WriteCount = write_count_reg;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder with the default parameters:
// WORD_SIZE=16, DEPTH=256, READ_LATENCY=2.
//
// Timing used throughout:
//   - Inputs are driven at the falling edge and sampled at the next rising edge.
//   - Outputs are observed at falling edges.
//   - After req() returns, the bench is one cycle past the request.
module tb_data_mem_responder;

  logic        Clock;
  logic        Reset;
  logic [15:0] DataAddr;
  logic [15:0] DataOut;
  logic        WriteData;
  logic        ReadData;
  logic [15:0] DataIn;
  logic        DataDone;
  logic        AddrErr;
`ifdef DATA_MEM_STATS_EN
  logic [15:0] ReadCount;
  logic [15:0] WriteCount;
`endif

  int checks = 0;
  int errors = 0;

  data_mem_responder #(
    .WORD_SIZE(16), .DEPTH(256), .READ_LATENCY(2)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .DataAddr  (DataAddr),
    .DataOut   (DataOut),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .DataIn    (DataIn),
    .DataDone  (DataDone),
`ifdef DATA_MEM_STATS_EN
    .ReadCount (ReadCount),
    .WriteCount(WriteCount),
`endif
    .AddrErr   (AddrErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Present one request for one cycle, then return to idle.
  task automatic req(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
    ReadData  = rd;
    WriteData = wr;
    DataAddr  = addr;
    DataOut   = wdata;
    $display("%0t req rd=%0b wr=%0b addr=%h data=%h", $time, rd, wr, addr, wdata);
    @(posedge Clock);
    #1;
    ReadData  = 1'b0;
    WriteData = 1'b0;
    @(negedge Clock);
  endtask

  // Idle cycle.
  task automatic step();
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    checks++; if (DataIn !== 16'h0000) begin errors++; $display("FAIL reset_datain: got %h expected 0000", DataIn); end
    checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", DataDone); end
    checks++; if (AddrErr !== 1'b0) begin errors++; $display("FAIL reset_addrerr: got %b expected 0", AddrErr); end
    Reset = 1'b0;
    step();
    checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL post_reset_done: got %b expected 0", DataDone); end
  endtask

  task automatic test_round_trip();
    req(1'b0, 1'b1, 16'h0005, 16'h1234);  // cycle 0: write
    req(1'b1, 1'b0, 16'h0005, 16'h0000);  // cycle 1: read
    // cycle 2: write completion; DataIn must not change
    checks++; if (DataDone !== 1'b1) begin errors++; $display("FAIL rt_write_done: got %b expected 1", DataDone); end
    checks++; if (DataIn !== 16'h0000) begin errors++; $display("FAIL rt_write_datain: got %h expected 0000", DataIn); end
    step();                               // cycle 3: read completion
    checks++; if (DataDone !== 1'b1) begin errors++; $display("FAIL rt_read_done: got %b expected 1", DataDone); end
    checks++; if (DataIn !== 16'h1234) begin errors++; $display("FAIL rt_read_data: got %h expected 1234", DataIn); end
    step();                               // cycle 4: quiet, value held
    checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL rt_idle_done: got %b expected 0", DataDone); end
    checks++; if (DataIn !== 16'h1234) begin errors++; $display("FAIL rt_hold: got %h expected 1234", DataIn); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) req(1'b0, 1'b1, 16'(i), 16'(16'h00A0 + i));
    repeat (2) step();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) req(1'b1, 1'b0, 16'(i), 16'h0000);
      else step();
      // Read i returns in the cycle after its req() returns + 1.
      if (i >= 1 && i <= 4) begin
        exp = 16'(16'h00A0 + i - 1);
        checks++; if (DataDone !== 1'b1) begin errors++; $display("FAIL stream_done_%0d: got %b expected 1", i - 1, DataDone); end
        checks++; if (DataIn !== exp) begin errors++; $display("FAIL stream_data_%0d: got %h expected %h", i - 1, DataIn, exp); end
      end
    end
    checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL stream_end_done: got %b expected 0", DataDone); end
    checks++; if (DataIn !== 16'h00A3) begin errors++; $display("FAIL stream_hold: got %h expected 00a3", DataIn); end
  endtask

  task automatic test_out_of_range();
    req(1'b1, 1'b0, 16'h0100, 16'h0000);
    checks++; if (AddrErr !== 1'b1) begin errors++; $display("FAIL oor_addrerr: got %b expected 1", AddrErr); end
    checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL oor_early_done: got %b expected 0", DataDone); end
    step();
    checks++; if (DataDone !== 1'b1) begin errors++; $display("FAIL oor_read_done: got %b expected 1", DataDone); end
    checks++; if (DataIn !== 16'h0000) begin errors++; $display("FAIL oor_read_data: got %h expected 0000", DataIn); end
    req(1'b0, 1'b1, 16'h0105, 16'hBEEF);
    step();
    checks++; if (DataDone !== 1'b1) begin errors++; $display("FAIL oor_write_done: got %b expected 1", DataDone); end
    req(1'b1, 1'b0, 16'h0005, 16'h0000);
    step();
    checks++; if (DataIn !== 16'h1234) begin errors++; $display("FAIL oor_mem_unchanged: got %h expected 1234", DataIn); end
    checks++; if (AddrErr !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b expected 1", AddrErr); end
  endtask

  task automatic test_illegal();
    do_reset();
    checks++; if (AddrErr !== 1'b0) begin errors++; $display("FAIL ill_pre_addrerr: got %b expected 0", AddrErr); end
    req(1'b1, 1'b1, 16'h0005, 16'h5555);
    checks++; if (AddrErr !== 1'b1) begin errors++; $display("FAIL ill_addrerr: got %b expected 1", AddrErr); end
    checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL ill_done_c1: got %b expected 0", DataDone); end
    step();
    checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL ill_done_c2: got %b expected 0", DataDone); end
    req(1'b1, 1'b0, 16'h0005, 16'h0000);
    step();
    checks++; if (DataIn !== 16'h1234) begin errors++; $display("FAIL ill_mem_unchanged: got %h expected 1234", DataIn); end
  endtask

  task automatic test_reset_mid_flight();
    req(1'b1, 1'b0, 16'h0001, 16'h0000);
    Reset = 1'b1;
    #1;
    checks++; if (DataIn !== 16'h0000) begin errors++; $display("FAIL rmf_datain: got %h expected 0000", DataIn); end
    checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL rmf_done_a: got %b expected 0", DataDone); end
    @(negedge Clock);
    checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL rmf_done_b: got %b expected 0", DataDone); end
    Reset = 1'b0;
    step();
    checks++; if (DataDone !== 1'b0) begin errors++; $display("FAIL rmf_done_c: got %b expected 0", DataDone); end
    req(1'b1, 1'b0, 16'h0002, 16'h0000);
    step();
    checks++; if (DataDone !== 1'b1) begin errors++; $display("FAIL rmf_read_done: got %b expected 1", DataDone); end
    checks++; if (DataIn !== 16'h00A2) begin errors++; $display("FAIL rmf_retained: got %h expected 00a2", DataIn); end
  endtask

`ifdef DATA_MEM_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++; if (ReadCount !== 16'h0000) begin errors++; $display("FAIL stats_rd_reset: got %h expected 0000", ReadCount); end
    req(1'b1, 1'b0, 16'h0000, 16'h0000);
    req(1'b1, 1'b0, 16'h0001, 16'h0000);
    req(1'b1, 1'b0, 16'h0100, 16'h0000);
    req(1'b0, 1'b1, 16'h0010, 16'h1111);
    req(1'b0, 1'b1, 16'h0011, 16'h2222);
    req(1'b1, 1'b1, 16'h0012, 16'h3333);
    repeat (3) step();
    checks++; if (ReadCount !== 16'd3) begin errors++; $display("FAIL stats_reads: got %0d expected 3", ReadCount); end
    checks++; if (WriteCount !== 16'd2) begin errors++; $display("FAIL stats_writes: got %0d expected 2", WriteCount); end
    force dut.write_count_reg = 16'hFFFF;
    @(negedge Clock);
    release dut.write_count_reg;
    req(1'b0, 1'b1, 16'h0013, 16'h4444);
    checks++; if (WriteCount !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate: got %h expected ffff", WriteCount); end
  endtask
`endif

  initial begin
    Reset     = 1'b1;
    ReadData  = 1'b0;
    WriteData = 1'b0;
    DataAddr  = '0;
    DataOut   = '0;
    test_reset();
    test_round_trip();
    test_back_to_back();
    test_out_of_range();
    test_illegal();
    test_reset_mid_flight();
`ifdef DATA_MEM_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
